// File: rtl/axi4b_pkg.sv
// Shared types and helpers for the AXI4 B-channel response scheduler.
// Holds the BRESP code enum, the counter width and the round-robin pick function.
package axi4b_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } bresp_t;

    // On a tie, the requester that was not granted last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] gnt;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/axi4b_rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant pointer register.
// The grant is gated by en, and the pointer only moves when a grant is actually issued.
module axi4b_rr_arb2
    import axi4b_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic       last_r;
    logic [1:0] pick_s;

    // Select a winner from the current requests and gate it with the enable.
    always_comb begin
        pick_s = rr_pick(req, last_r);
        if (en) begin
            gnt = pick_s;
        end else begin
            gnt = 2'b00;
        end
    end

    // The pointer resets to 1 so that source 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (en && (req != 2'b00)) begin
            last_r <= pick_s[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/axi4b_resp_sched.sv
// Schedules write responses from two per-ID sources onto one AXI4 B channel.
// Per-ID outstanding counters gate eligibility, and a one-deep output register allows zero-bubble reload.
module axi4b_resp_sched
    import axi4b_pkg::*;
#(
    parameter int MAX_OUTST = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       aw_fire,
    input  logic       aw_id,
    output logic       aw_full,
    input  logic       s0_valid,
    input  logic [1:0] s0_resp,
    input  logic       s1_valid,
    input  logic [1:0] s1_resp,
    output logic       s0_ready,
    output logic       s1_ready,
    output logic       bid,
    output logic [1:0] bresp,
    output logic       bvalid,
    input  logic       bready,
    output logic       err_ovf
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

    logic [0:0]       state_r;
    logic             bid_r;
    logic [1:0]       bresp_r;
    logic             err_ovf_r;
    logic [CNT_W-1:0] cnt_r     [2];
    logic [CNT_W-1:0] cnt_nxt_s [2];
    logic [1:0]       elig_s;
    logic [1:0]       gnt_s;
    logic [1:0]       inc_s;
    logic             load_en_s;
    logic             aw_full_s;
    logic [1:0]       sel_resp_s;

    // Eligibility, load enable, the selected response and the counter next values.
    always_comb begin
        elig_s[0]  = s0_valid && (cnt_r[0] != {CNT_W{1'b0}});
        elig_s[1]  = s1_valid && (cnt_r[1] != {CNT_W{1'b0}});
        load_en_s  = (state_r == ST_EMPTY) || bready;
        aw_full_s  = (cnt_r[aw_id] == MAX_C);
        if (gnt_s[1]) begin
            sel_resp_s = s1_resp;
        end else begin
            sel_resp_s = s0_resp;
        end
        for (int n = 0; n < 2; n++) begin
            inc_s[n]     = aw_fire && (aw_id == 1'(n)) && (cnt_r[n] != MAX_C);
            cnt_nxt_s[n] = cnt_r[n] + CNT_W'(inc_s[n]) - CNT_W'(gnt_s[n]);
        end
    end

    axi4b_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (elig_s),
        .en    (load_en_s),
        .gnt   (gnt_s)
    );

    // Outstanding counters and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r[0]  <= {CNT_W{1'b0}};
            cnt_r[1]  <= {CNT_W{1'b0}};
            err_ovf_r <= 1'b0;
        end else begin
            cnt_r[0]  <= cnt_nxt_s[0];
            cnt_r[1]  <= cnt_nxt_s[1];
            err_ovf_r <= err_ovf_r || (aw_fire && aw_full_s);
        end
    end

    // Output register: load on grant, drain to EMPTY when nothing is eligible, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            bid_r   <= 1'b0;
            bresp_r <= OKAY;
        end else if (load_en_s && (gnt_s != 2'b00)) begin
            state_r <= ST_FULL;
            bid_r   <= gnt_s[1];
            bresp_r <= sel_resp_s;
        end else if (load_en_s) begin
            state_r <= ST_EMPTY;
            bid_r   <= bid_r;
            bresp_r <= bresp_r;
        end else begin
            state_r <= state_r;
            bid_r   <= bid_r;
            bresp_r <= bresp_r;
        end
    end

    assign aw_full  = aw_full_s;
    assign s0_ready = gnt_s[0];
    assign s1_ready = gnt_s[1];
    assign bvalid   = (state_r == ST_FULL);
    assign bid      = bid_r;
    assign bresp    = bresp_r;
    assign err_ovf  = err_ovf_r;

endmodule

// File: doc/axi4b_resp_sched.md
AXI4B_RESP_SCHED -- requirements
Module: axi4b_resp_sched

Interface
REQ-001 Parameter: MAX_OUTST, default 15, maximum outstanding writes per ID (1..15).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  block clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 aw_fire  input  1  a write address was accepted upstream this cycle.
REQ-006 aw_id  input  1  ID of that write; sampled only when aw_fire=1.
REQ-007 aw_full  output  1  outstanding count for aw_id equals MAX_OUTST; upstream must not fire.
REQ-008 s0_valid / s1_valid  input  1  response source 0 / 1 (source index = bid) has a response.
REQ-009 s0_resp / s1_resp  input  2  BRESP code from each source.
REQ-010 s0_ready / s1_ready  output  1  source response accepted this cycle.
REQ-011 bid  output  1  B-channel ID.
REQ-012 bresp  output  2  B-channel response.
REQ-013 bvalid  output  1  B-channel valid.
REQ-014 bready  input  1  B-channel ready from manager.
REQ-015 err_ovf  output  1  sticky: aw_fire seen while that ID's count equals MAX_OUTST.

Function
REQ-016 Per-ID counters cnt[0], cnt[1], width 4: increment on aw_fire for aw_id; decrement when that source is accepted.
REQ-017 Simultaneous increment and decrement on the same ID leave the count unchanged.
REQ-018 aw_fire while cnt[aw_id]==MAX_OUTST: no increment; err_ovf set until reset.
REQ-019 Source n eligible = sn_valid and cnt[n]>0; an ineligible source is never accepted.
REQ-020 Output register FSM, states EMPTY and FULL; bvalid=1 exactly in FULL.
REQ-021 load_en = EMPTY, or FULL with bready=1 (zero-bubble reload; one response per cycle sustained).
REQ-022 When load_en and at least one source is eligible: grant one source, assert its sn_ready combinationally that cycle, and register bid=granted index and bresp=its sn_resp; state FULL.
REQ-023 FULL with bready=1 and no eligible source: state EMPTY; bid/bresp hold their last value.
REQ-024 FULL with bready=0: bid, bresp and bvalid hold stable; no source is accepted.
REQ-025 bvalid never depends combinationally on bready; latency source accept -> bvalid is 1 cycle.
REQ-026 Arbitration is round-robin: if both are eligible, grant the source not granted last; a single eligible source is granted regardless.
REQ-027 The last-grant pointer updates only on an actual grant.
REQ-028 aw_full is combinational from cnt[aw_id] and is valid every cycle.

Reset
REQ-029 Asynchronous assertion; all registers cleared immediately, independent of clk.
REQ-030 Reset values: bvalid=0, bid=0, bresp=OKAY, cnt[0]=cnt[1]=0, err_ovf=0, state EMPTY, last-grant=1 (source 0 wins the first tie).
REQ-031 Reset in FULL discards the held response with no B handshake; counters are not restored.
REQ-032 s0_ready/s1_ready are 0 while rst_n=0 and in the first cycle after release (cnt=0).

Structure
REQ-033 axi4b_pkg holds: BRESP codes OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3 as an enum typedef; CNT_W=4.
REQ-034 Sub-module axi4b_rr_arb2: 2-requester round-robin arbiter (req[1:0], grant enable -> one-hot gnt, pointer register).

Verification
REQ-035 aw_fire id0 x1; s0_valid resp=SLVERR, bready=1 -> next cycle bvalid=1 bid=0 bresp=2; cnt[0]=0 afterwards.
REQ-036 cnt[0]=cnt[1]=2, both sources valid every cycle, bready=1 -> bids 0,1,0,1 on consecutive cycles, no bubbles.
REQ-037 bvalid=1 bid=1 bresp=OKAY, bready=0 for 5 cycles with s0 valid -> outputs stable, s0_ready=0; bready=1 -> s0 loaded next cycle.
REQ-038 15 aw_fire on id1 -> aw_full=1; 16th aw_fire -> cnt[1] stays 15, err_ovf=1; same-cycle aw_fire and s1 accept on id1 -> cnt unchanged.
REQ-039 s1_valid=1 with cnt[1]=0 -> s1_ready=0, bvalid stays 0 for 10 cycles.
REQ-040 rst_n low mid-cycle while bvalid=1 -> bvalid=0 immediately; all counters read 0.
